load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage access controller between the pipeline's MEM-stage request and the word-addressed DataMemory.
- DataMemory reads combinationally and writes on the clock edge.
- Converts byte addresses into word indices and performs sub-word loads with sign or zero extension.
- Performs sub-word stores (SB/SH) as a read-modify-write sequence, and flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in DataMemory; a word index >= MEM_WORDS is out of range.
- OP_W, 3, width of the op code.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid_in  input  1  request present.
- req_ready_out  output  1  unit can accept a request.
- op_in  input  3  0=LB 1=LH 2=LW 3=LBU 4=LHU 5=SB 6=SH 7=SW.
- addr_in  input  32  byte address.
- wdata_in  input  32  store data; SB uses bits [7:0], SH uses bits [15:0].
- resp_valid_out  output  1  one-cycle completion pulse.
- rdata_out  output  32  load result; 0 for stores and faults.
- fault_out  output  2  00 ok, 01 misaligned, 10 out of range; valid with resp_valid_out.
- mem_addr_out  output  32  word index (byte address >> 2), zero-extended, to DataMemory address_in.
- mem_wdata_out  output  32  word to write, to DataMemory data_in.
- mem_write_out  output  1  write enable, to DataMemory write_in.
- mem_rdata_in  input  32  DataMemory data_out.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; every registered output and captured field clears to 0. req_ready_out becomes 1 once reset_n is released.
- States: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE:
  - req_ready_out=1; mem_write_out=0, mem_addr_out=0, mem_wdata_out=0.
  - On req_valid_in=1, capture op, addr and wdata.
  - Fault check at capture, misaligned taking priority over out of range:
    - misaligned = (LH/LHU/SH with addr[0]=1) or (LW/SW with addr[1:0]!=0).
    - out of range = addr[31:2] >= MEM_WORDS.
  - Fault -> RESP with fault_out set. Otherwise -> ACCESS.
- ACCESS (req_ready_out=0): mem_addr_out = captured addr[31:2].
  - Loads: register the extracted lane from mem_rdata_in, then -> RESP.
  - SW: mem_write_out=1 and mem_wdata_out = wdata, then -> RESP.
  - SB/SH: register the old word mem_rdata_in with the new lane merged in, then -> MERGE_WR.
- MERGE_WR: mem_addr_out is held; mem_write_out=1; mem_wdata_out = merged word; -> RESP.
- RESP: resp_valid_out=1 for exactly one cycle; no backpressure; -> IDLE. req_ready_out=0 in RESP.
- Byte lanes are little-endian: addr[1:0]=0 selects bits [7:0], 3 selects [31:24]; halfword addr[1]=0 selects [15:0].
- Load extension: LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word unchanged.
- SB/SH merge leaves all non-addressed byte lanes bit-identical to the old word.
- Latency from the acceptance edge to resp_valid_out high:
  - loads and SW: 2 cycles;
  - SB/SH: 3 cycles;
  - faults: 1 cycle.
- Outputs outside their active state:
  - mem_write_out is 0 outside ACCESS (SW only) and MERGE_WR.
  - mem_addr_out and mem_wdata_out are 0 in IDLE and RESP.
- A faulted request never asserts mem_write_out.
- Reset mid-operation: reset_n low forces IDLE and mem_write_out=0 immediately. If no write edge occurred yet, memory is unmodified and no response is issued.
- A request arriving while req_ready_out=0 is ignored; upstream must hold it.
- op and addr changing after capture have no effect.

Decomposition:
- Shared package lsu_pkg holds the op code constants (LB..SW), the fault code constants, and the state encoding.
- One natural sub-module, lsu_lane_logic (combinational):
  - load extract plus sign/zero extension from (word, addr[1:0], op);
  - store merge from (old word, wdata, addr[1:0], op).
- Keeping this sub-module separate allows standalone exhaustive testing.

Test Plan:
- Memory word 3 = 0x8899AABB. LB at addr 0x0D -> rdata 0xFFFFFFAA, fault 00, resp 2 cycles after acceptance. LBU at the same address -> 0x000000AA.
- LH at 0x0E on the same word -> 0xFFFF8899. LW at 0x0C -> 0x8899AABB.
- SB with wdata 0x12345677 at addr 0x0E, word 3 = 0x8899AABB -> exactly one mem_write_out pulse, in MERGE_WR; word 3 becomes 0x8877AABB; resp 3 cycles after acceptance.
- SW 0xDEADBEEF at 0x10 -> single write to word index 4, in ACCESS. A following LW at 0x10 returns 0xDEADBEEF.
- LW at 0x0A -> fault 01, resp 1 cycle after acceptance, mem_write_out never high. SW at 0x400 with MEM_WORDS=256 -> fault 10, no write.
- SH issued, then reset_n pulled low in ACCESS -> mem_write_out stays 0, the word is unchanged, no resp, and req_ready_out=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, fault codes and the
// FSM state encoding, plus a small helper used by the top level.
package lsu_pkg;

  // Op codes presented on op_in.
  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  // Fault codes reported on fault_out alongside resp_valid.
  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACCESS   = 2'd1;
  localparam logic [1:0] ST_MERGE_WR = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  // Stores occupy the top three op codes.
  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsu_lane_logic.sv
// Combinational byte-lane logic for the load/store unit.
//   op        : op code (lsu_pkg OP_*)
//   byte_off  : byte address bits [1:0]
//   word      : word read from DataMemory
//   wdata     : store data (SB uses [7:0], SH uses [15:0])
//   load_data : extracted and sign/zero-extended load result (0 for stores)
//   merged    : old word with the store lane replaced (word itself for SW/loads)
module lsu_lane_logic
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  bit_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lanes: byte offset 0 is bits [7:0].
  assign bit_off  = {byte_off, 3'b000};
  assign byte_sel = word[bit_off +: 8];
  assign half_sel = byte_off[1] ? word[31:16] : word[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    load_data = '0;
    merged    = word;
    case (op)
      OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      OP_LW:  load_data = word;
      OP_LBU: load_data = {24'h0, byte_sel};
      OP_LHU: load_data = {16'h0, half_sel};
      OP_SB:  merged[bit_off +: 8] = wdata[7:0];
      OP_SH: begin
        if (byte_off[1]) merged[31:16] = wdata[15:0];
        else             merged[15:0]  = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage access controller between the MEM-stage request and a
// word-addressed DataMemory (combinational read, clocked write).
//   clk, reset_n            : clock, asynchronous active-low reset
//   req_valid_in/ready_out  : request handshake; op_in, addr_in, wdata_in
//   resp_valid_out          : one-cycle completion pulse with rdata_out, fault_out
//   mem_addr_out            : word index to DataMemory
//   mem_wdata_out/write_out : write data and enable to DataMemory
//   mem_rdata_in            : DataMemory read data
// Sub-word stores are done as read (ACCESS) then write (MERGE_WR).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int OP_W      = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic [OP_W-1:0] op_in,
  input  logic [31:0]     addr_in,
  input  logic [31:0]     wdata_in,
  output logic            resp_valid_out,
  output logic [31:0]     rdata_out,
  output logic [1:0]      fault_out,
  output logic [31:0]     mem_addr_out,
  output logic [31:0]     mem_wdata_out,
  output logic            mem_write_out,
  input  logic [31:0]     mem_rdata_in
);

  logic [1:0]      state;
  logic [OP_W-1:0] op_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic [31:0]     merge_q;
  logic [1:0]      fault_q;

  logic            misaligned;
  logic            out_of_range;
  logic            sub_store;
  logic            in_access;
  logic            in_merge;
  logic [31:0]     load_data;
  logic [31:0]     merged;

  // Faults are judged on the incoming request at capture time.
  assign misaligned =
      (((op_in == OP_LH) || (op_in == OP_LHU) || (op_in == OP_SH)) && addr_in[0]) ||
      (((op_in == OP_LW) || (op_in == OP_SW)) && (addr_in[1:0] != 2'b00));
  assign out_of_range = {2'b00, addr_in[31:2]} >= 32'(MEM_WORDS);

  assign sub_store = (op_q == OP_SB) || (op_q == OP_SH);
  assign in_access = (state == ST_ACCESS);
  assign in_merge  = (state == ST_MERGE_WR);

  lsu_lane_logic u_lane (
    .op        (op_q),
    .byte_off  (addr_q[1:0]),
    .word      (mem_rdata_in),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
      fault_q <= FAULT_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_in) begin
            op_q    <= op_in;
            addr_q  <= addr_in;
            wdata_q <= wdata_in;
            rdata_q <= '0;
            merge_q <= '0;
            if (misaligned) begin
              fault_q <= FAULT_MISALIGN;
              state   <= ST_RESP;
            end else if (out_of_range) begin
              fault_q <= FAULT_RANGE;
              state   <= ST_RESP;
            end else begin
              fault_q <= FAULT_OK;
              state   <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (sub_store) begin
            merge_q <= merged;
            state   <= ST_MERGE_WR;
          end else begin
            if (!is_store(op_q)) rdata_q <= load_data;
            state <= ST_RESP;
          end
        end
        ST_MERGE_WR: state <= ST_RESP;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_out  = (state == ST_IDLE);
  assign resp_valid_out = (state == ST_RESP);
  assign rdata_out      = resp_valid_out ? rdata_q : '0;
  assign fault_out      = resp_valid_out ? fault_q : FAULT_OK;

  // Memory-side signals are only live while a word is being accessed.
  assign mem_addr_out  = (in_access || in_merge) ? {2'b00, addr_q[31:2]} : '0;
  assign mem_write_out = (in_access && (op_q == OP_SW)) || in_merge;
  assign mem_wdata_out = in_merge                      ? merge_q :
                         (in_access && op_q == OP_SW)  ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural DataMemory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [2:0]  op_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        resp_valid_out;
  logic [31:0] rdata_out;
  logic [1:0]  fault_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic        mem_write_out;
  logic [31:0] mem_rdata_in;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [256];
  int          write_cnt = 0;
  int          last_wr_idx = -1;
  int          resp_cnt = 0;

  load_store_unit #(.MEM_WORDS(256), .OP_W(3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .op_in          (op_in),
    .addr_in        (addr_in),
    .wdata_in       (wdata_in),
    .resp_valid_out (resp_valid_out),
    .rdata_out      (rdata_out),
    .fault_out      (fault_out),
    .mem_addr_out   (mem_addr_out),
    .mem_wdata_out  (mem_wdata_out),
    .mem_write_out  (mem_write_out),
    .mem_rdata_in   (mem_rdata_in)
  );

  always #5 clk = ~clk;

  // DataMemory model: combinational read, write on rising edge.
  assign mem_rdata_in = (mem_addr_out < 32'd256) ? mem[mem_addr_out[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write_out) begin
      mem[mem_addr_out[7:0]] <= mem_wdata_out;
      write_cnt   = write_cnt + 1;
      last_wr_idx = int'(mem_addr_out);
    end
    if (resp_valid_out) resp_cnt = resp_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic [1:0] fault,
                        output logic got);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready_out && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    write_cnt    = 0;
    last_wr_idx  = -1;
    req_valid_in = 1'b1;
    op_in        = op;
    addr_in      = addr;
    wdata_in     = wdata;
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
    lat = 1;
    while (!resp_valid_out && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got   = resp_valid_out;
    rdata = rdata_out;
    fault = fault_out;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_fault;
    int          exp_lat;
    int          exp_writes;
    int          chk_idx;    // word to inspect afterwards, -1 for none
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [1:0]  ft;
    logic        got;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[3]   = 32'h8899AABB;
    mem[5]   = 32'h11223344;
    mem[255] = 32'h7F000000;

    vecs.push_back('{"lb_0d",   OP_LB,  32'h0D,  32'h0, 32'hFFFFFFAA, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"lbu_0d",  OP_LBU, 32'h0D,  32'h0, 32'h000000AA, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"lb_0c",   OP_LB,  32'h0C,  32'h0, 32'hFFFFFFBB, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"lb_0f",   OP_LB,  32'h0F,  32'h0, 32'hFFFFFF88, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"lh_0e",   OP_LH,  32'h0E,  32'h0, 32'hFFFF8899, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"lhu_0e",  OP_LHU, 32'h0E,  32'h0, 32'h00008899, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"lh_0c",   OP_LH,  32'h0C,  32'h0, 32'hFFFFAABB, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"lw_0c",   OP_LW,  32'h0C,  32'h0, 32'h8899AABB, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"lw_0a",   OP_LW,  32'h0A,  32'h0, 32'h0, FAULT_MISALIGN, 1, 0, -1, 32'h0});
    vecs.push_back('{"lh_0d",   OP_LH,  32'h0D,  32'h0, 32'h0, FAULT_MISALIGN, 1, 0, -1, 32'h0});
    vecs.push_back('{"sw_400",  OP_SW,  32'h400, 32'h1, 32'h0, FAULT_RANGE,    1, 0, -1, 32'h0});
    vecs.push_back('{"sh_401",  OP_SH,  32'h401, 32'h1, 32'h0, FAULT_MISALIGN, 1, 0, -1, 32'h0});
    vecs.push_back('{"lb_400",  OP_LB,  32'h400, 32'h0, 32'h0, FAULT_RANGE,    1, 0, -1, 32'h0});
    vecs.push_back('{"lb_3ff",  OP_LB,  32'h3FF, 32'h0, 32'h0000007F, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"lw_3fc",  OP_LW,  32'h3FC, 32'h0, 32'h7F000000, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"sb_0e",   OP_SB,  32'h0E,  32'h12345677, 32'h0, FAULT_OK, 3, 1, 3, 32'h8877AABB});
    vecs.push_back('{"lw_0c_b", OP_LW,  32'h0C,  32'h0, 32'h8877AABB, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"sw_10",   OP_SW,  32'h10,  32'hDEADBEEF, 32'h0, FAULT_OK, 2, 1, 4, 32'hDEADBEEF});
    vecs.push_back('{"lw_10",   OP_LW,  32'h10,  32'h0, 32'hDEADBEEF, FAULT_OK, 2, 0, -1, 32'h0});
    vecs.push_back('{"sh_0e",   OP_SH,  32'h0E,  32'h0000CAFE, 32'h0, FAULT_OK, 3, 1, 3, 32'hCAFEAABB});
    vecs.push_back('{"sh_0c",   OP_SH,  32'h0C,  32'hFFFF1357, 32'h0, FAULT_OK, 3, 1, 3, 32'hCAFE1357});
    vecs.push_back('{"lhu_0e",  OP_LHU, 32'h0E,  32'h0, 32'h0000CAFE, FAULT_OK, 2, 0, -1, 32'h0});

    // Reset state.
    reset_n      = 1'b0;
    req_valid_in = 1'b0;
    op_in        = 3'd0;
    addr_in      = 32'h0;
    wdata_in     = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready",  32'(req_ready_out),  32'd1);
    check("rst_resp",   32'(resp_valid_out), 32'd0);
    check("rst_write",  32'(mem_write_out),  32'd0);
    check("rst_maddr",  mem_addr_out,        32'h0);
    check("rst_mwdata", mem_wdata_out,       32'h0);
    check("rst_rdata",  rdata_out,           32'h0);
    check("rst_fault",  32'(fault_out),      32'd0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, rd, ft, got);
      check({vecs[i].name, "_resp"},   32'(got),   32'd1);
      check({vecs[i].name, "_lat"},    32'(lat),   32'(vecs[i].exp_lat));
      check({vecs[i].name, "_rdata"},  rd,         vecs[i].exp_rdata);
      check({vecs[i].name, "_fault"},  32'(ft),    32'(vecs[i].exp_fault));
      check({vecs[i].name, "_writes"}, 32'(write_cnt), 32'(vecs[i].exp_writes));
      if (vecs[i].chk_idx >= 0) begin
        check({vecs[i].name, "_wr_idx"}, 32'(last_wr_idx), 32'(vecs[i].chk_idx));
        check({vecs[i].name, "_word"},   mem[vecs[i].chk_idx], vecs[i].exp_word);
      end
      @(posedge clk);
      #1;
      check({vecs[i].name, "_pulse_end"}, 32'(resp_valid_out), 32'd0);
      check({vecs[i].name, "_ready_back"}, 32'(req_ready_out), 32'd1);
    end

    // Inputs changing after capture, and a request held while busy, are ignored.
    @(negedge clk);
    write_cnt    = 0;
    req_valid_in = 1'b1;
    op_in        = OP_LW;
    addr_in      = 32'h0C;
    wdata_in     = 32'h0;
    @(posedge clk);
    #1;
    op_in    = OP_SW;
    addr_in  = 32'h10;
    wdata_in = 32'h55555555;
    check("busy_ready", 32'(req_ready_out), 32'd0);
    lat = 1;
    while (!resp_valid_out && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    req_valid_in = 1'b0;
    check("busy_lat",    32'(lat),   32'd2);
    check("busy_rdata",  rdata_out,  32'hCAFE1357);
    check("busy_writes", 32'(write_cnt), 32'd0);
    check("busy_word4",  mem[4],     32'hDEADBEEF);

    // Reset asserted while an SH sits in ACCESS.
    repeat (2) @(posedge clk);
    @(negedge clk);
    write_cnt    = 0;
    resp_cnt     = 0;
    req_valid_in = 1'b1;
    op_in        = OP_SH;
    addr_in      = 32'h16;
    wdata_in     = 32'h0000BEEF;
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
    check("rstmid_in_access_wr", 32'(mem_write_out), 32'd0);
    check("rstmid_in_access_rdy", 32'(req_ready_out), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check("rstmid_write_low", 32'(mem_write_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid_ready",  32'(req_ready_out), 32'd1);
    check("rstmid_writes", 32'(write_cnt),     32'd0);
    check("rstmid_resps",  32'(resp_cnt),      32'd0);
    check("rstmid_word5",  mem[5],             32'h11223344);

    // Unit is usable after the mid-operation reset.
    do_req(OP_LHU, 32'h16, 32'h0, lat, rd, ft, got);
    check("post_rst_rdata", rd,        32'h00001122);
    check("post_rst_lat",   32'(lat),  32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
